// File: rtl/vip_frame_scheduler.sv
// Frame-level scheduler for the video pipeline: qualifies frame geometry, gates processing
// through warm-up and error-driven resync, and shadows runtime config to frame boundaries.
module vip_frame_scheduler #(
    parameter logic [9:0] IMG_HDISP      = 10'd640,
    parameter logic [9:0] IMG_VDISP      = 10'd480,
    parameter logic [3:0] WARMUP_FRAMES  = 4'd2,
    parameter logic [3:0] ERR_LIMIT      = 4'd3,
    parameter logic [7:0] THRESH_DEFAULT = 8'd40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic        enable,
    input  logic        cfg_wr,
    input  logic [7:0]  cfg_threshold,
    input  logic [1:0]  cfg_mode,
    output logic [7:0]  sobel_threshold,
    output logic [1:0]  mode_sel,
    output logic        proc_en,
    output logic        cfg_pending,
    output logic        frame_err,
    output logic [7:0]  err_cnt,
    output logic [15:0] frame_cnt
);
    typedef enum logic [1:0] {IDLE, WAIT_SOF, WARMUP, RUN} state_t;

    state_t      state_reg, state_next;
    logic        proc_en_next;
    logic        vsync_reg, href_reg, sync_ok_reg, sof_reg, eof_reg;
    logic        sof, eof, sol, eol;
    logic [9:0]  pix_cnt_reg, line_cnt_reg;
    logic        line_bad_reg;
    logic [3:0]  clean_cnt_reg, bad_cnt_reg, clean_inc, bad_inc;
    logic        frame_bad, eval, apply;
    logic [7:0]  pend_thresh_reg;
    logic [1:0]  pend_mode_reg;

    // A rising vsync only counts once vsync has been seen low, so a frame already
    // in flight when reset releases never looks like a fresh start.
    assign sof = per_frame_vsync & ~vsync_reg & sync_ok_reg;
    assign eof = ~per_frame_vsync & vsync_reg;
    assign sol = per_frame_href & ~href_reg;
    assign eol = ~per_frame_href & href_reg;

    assign frame_bad = line_bad_reg | (line_cnt_reg != IMG_VDISP);
    assign eval      = eof_reg & ((state_reg == WARMUP) | (state_reg == RUN));
    assign clean_inc = clean_cnt_reg + 4'd1;
    assign bad_inc   = bad_cnt_reg + 4'd1;
    assign apply     = eof_reg | (((state_reg == IDLE) | (state_reg == WAIT_SOF))
                                  & ~per_frame_vsync & ~vsync_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_reg   <= 1'b0;
            href_reg    <= 1'b0;
            sync_ok_reg <= 1'b0;
            sof_reg     <= 1'b0;
            eof_reg     <= 1'b0;
        end else begin
            vsync_reg   <= per_frame_vsync;
            href_reg    <= per_frame_href;
            sync_ok_reg <= sync_ok_reg | ~per_frame_vsync;
            sof_reg     <= sof;
            eof_reg     <= eof;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_reg  <= '0;
            line_cnt_reg <= '0;
            line_bad_reg <= 1'b0;
        end else begin
            if (sol)
                pix_cnt_reg <= {9'd0, per_frame_clken};
            else if (per_frame_href && per_frame_clken && pix_cnt_reg != 10'd1023)
                pix_cnt_reg <= pix_cnt_reg + 10'd1;

            if (sof)
                line_cnt_reg <= {9'd0, sol};
            else if (sol && line_cnt_reg != 10'd1023)
                line_cnt_reg <= line_cnt_reg + 10'd1;

            if (sof)
                line_bad_reg <= 1'b0;
            else if (eol && pix_cnt_reg != IMG_HDISP)
                line_bad_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            proc_en   <= 1'b0;
        end else begin
            state_reg <= state_next;
            proc_en   <= proc_en_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (enable) state_next = WAIT_SOF;
            WAIT_SOF: if (sof_reg) state_next = WARMUP;
            WARMUP:   if (eof_reg && !frame_bad && clean_inc >= WARMUP_FRAMES) state_next = RUN;
            RUN:      if (eof_reg && frame_bad && bad_inc >= ERR_LIMIT) state_next = WAIT_SOF;
            default:  state_next = IDLE;
        endcase
        // Registered vsync is low both between frames and on the EOF evaluation cycle.
        if (!enable && !vsync_reg)
            state_next = IDLE;
    end

    always_comb begin
        proc_en_next = (state_next == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err     <= 1'b0;
            err_cnt       <= '0;
            frame_cnt     <= '0;
            clean_cnt_reg <= '0;
            bad_cnt_reg   <= '0;
        end else begin
            frame_err <= eval & frame_bad;
            if (eval)
                frame_cnt <= frame_cnt + 16'd1;
            if (eval && frame_bad && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;

            if (state_reg == WAIT_SOF && sof_reg)
                clean_cnt_reg <= '0;
            else if (state_reg == WARMUP && eof_reg)
                clean_cnt_reg <= frame_bad ? 4'd0 : clean_inc;

            if (state_reg == IDLE)
                bad_cnt_reg <= '0;
            else if (eval && frame_bad) begin
                if (state_reg == RUN && bad_inc >= ERR_LIMIT)
                    bad_cnt_reg <= '0;
                else if (bad_cnt_reg != 4'hF)
                    bad_cnt_reg <= bad_inc;
            end else if (eval && state_reg == RUN)
                bad_cnt_reg <= '0;
        end
    end

    // A write landing on an apply cycle bypasses the pending registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_thresh_reg <= THRESH_DEFAULT;
            pend_mode_reg   <= 2'd0;
            sobel_threshold <= THRESH_DEFAULT;
            mode_sel        <= 2'd0;
            cfg_pending     <= 1'b0;
        end else begin
            if (cfg_wr) begin
                pend_thresh_reg <= cfg_threshold;
                pend_mode_reg   <= cfg_mode;
            end
            if (apply) begin
                if (cfg_wr) begin
                    sobel_threshold <= cfg_threshold;
                    mode_sel        <= cfg_mode;
                end else if (cfg_pending) begin
                    sobel_threshold <= pend_thresh_reg;
                    mode_sel        <= pend_mode_reg;
                end
                cfg_pending <= 1'b0;
            end else if (cfg_wr) begin
                cfg_pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vip_frame_scheduler.sv
// Directed bench for vip_frame_scheduler using a reduced 8x4 frame geometry.
module tb_vip_frame_scheduler;
    localparam int HD = 8;
    localparam int VD = 4;

    logic        clk = 1'b0;
    logic        rst_n, vsync, href, clken, enable, cfg_wr;
    logic [7:0]  cfg_threshold;
    logic [1:0]  cfg_mode;
    logic [7:0]  sobel_threshold;
    logic [1:0]  mode_sel;
    logic        proc_en, cfg_pending, frame_err;
    logic [7:0]  err_cnt;
    logic [15:0] frame_cnt;
    int n_cmp = 0;
    int n_bad = 0;

    vip_frame_scheduler #(
        .IMG_HDISP(10'd8), .IMG_VDISP(10'd4), .WARMUP_FRAMES(4'd2),
        .ERR_LIMIT(4'd3), .THRESH_DEFAULT(8'd40)
    ) dut (
        .clk(clk), .rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href),
        .per_frame_clken(clken), .enable(enable), .cfg_wr(cfg_wr),
        .cfg_threshold(cfg_threshold), .cfg_mode(cfg_mode),
        .sobel_threshold(sobel_threshold), .mode_sel(mode_sel), .proc_en(proc_en),
        .cfg_pending(cfg_pending), .frame_err(frame_err), .err_cnt(err_cnt),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) step();
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        step();
        step();
    endtask

    task automatic send_line(input int len);
        href = 1'b1;
        clken = 1'b1;
        repeat (len) step();
        href = 1'b0;
        clken = 1'b0;
        step();
        step();
    endtask

    task automatic frame_end();
        step();
        vsync = 1'b0;
    endtask

    task automatic send_frame(input int lines, input int bad_idx, input int bad_len);
        frame_start();
        for (int i = 0; i < lines; i++) send_line(i == bad_idx ? bad_len : HD);
        frame_end();
    endtask

    task automatic cfg_write(input logic [7:0] t, input logic [1:0] m);
        cfg_wr = 1'b1;
        cfg_threshold = t;
        cfg_mode = m;
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        n_cmp++; if (sobel_threshold !== 8'd40) begin n_bad++; $display("FAIL %s_thresh: got %0d want 40", tag, sobel_threshold); end
        n_cmp++; if (mode_sel !== 2'd0) begin n_bad++; $display("FAIL %s_mode: got %0d want 0", tag, mode_sel); end
        n_cmp++; if (proc_en !== 1'b0) begin n_bad++; $display("FAIL %s_proc_en: got %0b want 0", tag, proc_en); end
        n_cmp++; if (cfg_pending !== 1'b0) begin n_bad++; $display("FAIL %s_pending: got %0b want 0", tag, cfg_pending); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL %s_frame_err: got %0b want 0", tag, frame_err); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL %s_err_cnt: got %0d want 0", tag, err_cnt); end
        n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL %s_frame_cnt: got %0d want 0", tag, frame_cnt); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vsync = 1'b0; href = 1'b0; clken = 1'b0; enable = 1'b0;
        cfg_wr = 1'b0; cfg_threshold = 8'd0; cfg_mode = 2'd0;
        gap(3);
        check_reset_values("reset");
        rst_n = 1'b1;
        gap(2);
        $display("reset: released, thresh=%0d proc_en=%0b", sobel_threshold, proc_en);
    endtask

    task automatic test_warmup();
        enable = 1'b1;
        gap(3);
        send_frame(VD, -1, 0);
        gap(4);
        n_cmp++; if (proc_en !== 1'b0) begin n_bad++; $display("FAIL warmup_f1_proc_en: got %0b want 0", proc_en); end
        send_frame(VD, -1, 0);
        step();
        n_cmp++; if (proc_en !== 1'b0) begin n_bad++; $display("FAIL warmup_eof1_proc_en: got %0b want 0", proc_en); end
        step();
        n_cmp++; if (proc_en !== 1'b1) begin n_bad++; $display("FAIL warmup_eof2_proc_en: got %0b want 1", proc_en); end
        gap(3);
        send_frame(VD, -1, 0);
        gap(4);
        n_cmp++; if (frame_cnt !== 16'd3) begin n_bad++; $display("FAIL warmup_frame_cnt: got %0d want 3", frame_cnt); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL warmup_err_cnt: got %0d want 0", err_cnt); end
        $display("warmup: frame_cnt=%0d err_cnt=%0d proc_en=%0b", frame_cnt, err_cnt, proc_en);
    endtask

    task automatic test_short_line();
        send_frame(VD, 1, HD - 1);
        step();
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL short_err_early: got %0b want 0", frame_err); end
        step();
        n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL short_err_pulse: got %0b want 1", frame_err); end
        n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL short_err_cnt: got %0d want 1", err_cnt); end
        n_cmp++; if (proc_en !== 1'b1) begin n_bad++; $display("FAIL short_proc_en: got %0b want 1", proc_en); end
        step();
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL short_err_width: got %0b want 0", frame_err); end
        gap(3);
        send_frame(VD, -1, 0);
        gap(4);
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL short_clean_err: got %0b want 0", frame_err); end
        $display("short_line: err_cnt=%0d proc_en=%0b", err_cnt, proc_en);
    endtask

    task automatic test_resync();
        for (int k = 0; k < 3; k++) begin
            send_frame(VD - 1, -1, 0);
            step();
            n_cmp++; if (proc_en !== 1'b1) begin n_bad++; $display("FAIL resync%0d_proc_en_a: got %0b want 1", k, proc_en); end
            step();
            n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL resync%0d_frame_err: got %0b want 1", k, frame_err); end
            n_cmp++; if (proc_en !== (k < 2)) begin n_bad++; $display("FAIL resync%0d_proc_en_b: got %0b want %0b", k, proc_en, k < 2); end
            gap(3);
        end
        n_cmp++; if (err_cnt !== 8'd4) begin n_bad++; $display("FAIL resync_err_cnt: got %0d want 4", err_cnt); end
        send_frame(VD, -1, 0);
        gap(4);
        n_cmp++; if (proc_en !== 1'b0) begin n_bad++; $display("FAIL resync_rec1_proc_en: got %0b want 0", proc_en); end
        send_frame(VD, -1, 0);
        step();
        step();
        n_cmp++; if (proc_en !== 1'b1) begin n_bad++; $display("FAIL resync_rec2_proc_en: got %0b want 1", proc_en); end
        n_cmp++; if (frame_cnt !== 16'd10) begin n_bad++; $display("FAIL resync_frame_cnt: got %0d want 10", frame_cnt); end
        gap(3);
        $display("resync: err_cnt=%0d frame_cnt=%0d proc_en=%0b", err_cnt, frame_cnt, proc_en);
    endtask

    task automatic test_cfg_shadow();
        frame_start();
        send_line(HD);
        send_line(HD);
        cfg_write(8'd80, 2'd1);
        n_cmp++; if (cfg_pending !== 1'b1) begin n_bad++; $display("FAIL cfg_pending_set: got %0b want 1", cfg_pending); end
        n_cmp++; if (sobel_threshold !== 8'd40) begin n_bad++; $display("FAIL cfg_hold_mid: got %0d want 40", sobel_threshold); end
        send_line(HD);
        send_line(HD);
        frame_end();
        step();
        n_cmp++; if (sobel_threshold !== 8'd40) begin n_bad++; $display("FAIL cfg_hold_eof1: got %0d want 40", sobel_threshold); end
        step();
        n_cmp++; if (sobel_threshold !== 8'd80) begin n_bad++; $display("FAIL cfg_apply_thresh: got %0d want 80", sobel_threshold); end
        n_cmp++; if (mode_sel !== 2'd1) begin n_bad++; $display("FAIL cfg_apply_mode: got %0d want 1", mode_sel); end
        n_cmp++; if (cfg_pending !== 1'b0) begin n_bad++; $display("FAIL cfg_pending_clr: got %0b want 0", cfg_pending); end
        gap(3);
        frame_start();
        send_line(HD);
        cfg_write(8'd60, 2'd2);
        send_line(HD);
        cfg_write(8'd90, 2'd3);
        send_line(HD);
        send_line(HD);
        frame_end();
        step();
        step();
        n_cmp++; if (sobel_threshold !== 8'd90) begin n_bad++; $display("FAIL cfg_last_thresh: got %0d want 90", sobel_threshold); end
        n_cmp++; if (mode_sel !== 2'd3) begin n_bad++; $display("FAIL cfg_last_mode: got %0d want 3", mode_sel); end
        gap(3);
        $display("cfg_shadow: thresh=%0d mode=%0d", sobel_threshold, mode_sel);
    endtask

    task automatic test_cfg_at_eof();
        send_frame(VD, -1, 0);
        step();
        cfg_write(8'd70, 2'd0);
        n_cmp++; if (sobel_threshold !== 8'd70) begin n_bad++; $display("FAIL eofwr_thresh: got %0d want 70", sobel_threshold); end
        n_cmp++; if (cfg_pending !== 1'b0) begin n_bad++; $display("FAIL eofwr_pending: got %0b want 0", cfg_pending); end
        step();
        n_cmp++; if (cfg_pending !== 1'b0) begin n_bad++; $display("FAIL eofwr_pending_after: got %0b want 0", cfg_pending); end
        gap(3);
        $display("cfg_at_eof: thresh=%0d pending=%0b", sobel_threshold, cfg_pending);
    endtask

    task automatic test_enable_drop();
        frame_start();
        send_line(HD);
        enable = 1'b0;
        for (int i = 1; i < VD; i++) send_line(HD);
        frame_end();
        step();
        n_cmp++; if (proc_en !== 1'b1) begin n_bad++; $display("FAIL endrop_proc_en_a: got %0b want 1", proc_en); end
        step();
        n_cmp++; if (proc_en !== 1'b0) begin n_bad++; $display("FAIL endrop_proc_en_b: got %0b want 0", proc_en); end
        n_cmp++; if (frame_cnt !== 16'd14) begin n_bad++; $display("FAIL endrop_frame_cnt: got %0d want 14", frame_cnt); end
        gap(3);
        send_frame(VD - 1, -1, 0);
        gap(4);
        n_cmp++; if (frame_cnt !== 16'd14) begin n_bad++; $display("FAIL idle_frame_cnt: got %0d want 14", frame_cnt); end
        n_cmp++; if (frame_err !== 1'b0 || err_cnt !== 8'd4) begin n_bad++; $display("FAIL idle_err: got %0b/%0d want 0/4", frame_err, err_cnt); end
        cfg_write(8'd33, 2'd2);
        n_cmp++; if (sobel_threshold !== 8'd33 || cfg_pending !== 1'b0) begin n_bad++; $display("FAIL idle_cfg: got %0d/%0b want 33/0", sobel_threshold, cfg_pending); end
        $display("enable_drop: frame_cnt=%0d thresh=%0d", frame_cnt, sobel_threshold);
    endtask

    task automatic test_reset_mid_frame();
        enable = 1'b1;
        gap(3);
        send_frame(VD, -1, 0);
        gap(3);
        send_frame(VD, -1, 0);
        gap(4);
        n_cmp++; if (proc_en !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_proc_en: got %0b want 1", proc_en); end
        frame_start();
        send_line(HD);
        rst_n = 1'b0;
        #1;
        check_reset_values("rstmid_async");
        step();
        rst_n = 1'b1;
        send_line(HD);
        send_line(HD - 2);
        frame_end();
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_frame_err%0d: got %0b want 0", i, frame_err); end
        end
        n_cmp++; if (err_cnt !== 8'd0 || frame_cnt !== 16'd0) begin n_bad++; $display("FAIL rstmid_counts: got %0d/%0d want 0/0", err_cnt, frame_cnt); end
        $display("reset_mid_frame: err_cnt=%0d frame_cnt=%0d", err_cnt, frame_cnt);
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_short_line();
        test_resync();
        test_cfg_shadow();
        test_cfg_at_eof();
        test_enable_drop();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
